// File: rtl/config_frame_pkg.sv
// Shared constants and types for the configuration frame loader.
package config_frame_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

  // Header field positions
  localparam int unsigned DESYNC_BIT = 31;
  localparam int unsigned COL_HI     = 15;
  localparam int unsigned COL_LO     = 8;
  localparam int unsigned FRM_HI     = 4;
  localparam int unsigned FRM_LO     = 0;

  localparam int unsigned COL_W = COL_HI - COL_LO + 1;
  localparam int unsigned FRM_W = FRM_HI - FRM_LO + 1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    STROBE = 2'd3
  } state_e;

endpackage

// File: rtl/cfg_word_assembler.sv
// Byte-to-word assembler: 2-bit byte counter plus shift history.
// word/window include the byte being accepted this cycle, so the FSM can act
// on the same edge that accepts the last byte of a word.
module cfg_word_assembler
  import config_frame_pkg::*;
(
  input  logic                UserCLK,
  input  logic                resetn,
  input  logic [BYTE_W-1:0]   in_data,
  input  logic                accept,
  input  logic                clear,
  output logic [WORD_W-1:0]   word,
  output logic                word_valid,
  output logic [WORD_W-1:0]   window
);

  localparam int unsigned HistW = WORD_W - BYTE_W;

  logic [1:0]       byte_cnt_q;
  logic [HistW-1:0] hist_q;

  // Byte history and position within the current word
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      byte_cnt_q <= 2'd0;
      hist_q     <= '0;
    end else if (clear) begin
      byte_cnt_q <= 2'd0;
      hist_q     <= '0;
    end else if (accept) begin
      byte_cnt_q <= byte_cnt_q + 2'd1;
      hist_q     <= {hist_q[HistW-BYTE_W-1:0], in_data};
    end
  end

  // Current 4-byte view, big-endian, newest byte in the LSBs
  always_comb begin
    window     = {hist_q, in_data};
    word       = {hist_q, in_data};
    word_valid = accept && (byte_cnt_q == 2'd3);
  end

endmodule

// File: rtl/config_frame_loader.sv
// Bitstream front end: sync hunt, header decode, frame assembly and strobe.
module config_frame_loader
  import config_frame_pkg::*;
#(
  parameter int unsigned NumRows         = 2,
  parameter int unsigned NumColumns      = 4,
  parameter int unsigned MaxFramesPerCol = 20
) (
  input  logic                                  UserCLK,
  input  logic                                  resetn,
  input  logic [7:0]                            in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [32*NumRows-1:0]                 FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  cfg_done,
  output logic                                  cfg_error
);

  localparam int unsigned DataW   = WORD_W * NumRows;
  localparam int unsigned StrobeW = NumColumns * MaxFramesPerCol;
  localparam int unsigned WcntW   = (NumRows > 1) ? $clog2(NumRows) : 1;

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [FRM_W-1:0]   frm_q, frm_d;
  logic [WcntW-1:0]   wcnt_q, wcnt_d;
  logic [DataW-1:0]   frame_data_d;
  logic [StrobeW-1:0] strobe_d;
  logic               done_d, error_d;

  logic               accept_c;
  logic               asm_clear_c;
  logic [WORD_W-1:0]  word_c;
  logic               word_valid_c;
  logic [WORD_W-1:0]  window_c;
  logic [COL_W-1:0]   hdr_col_c;
  logic [FRM_W-1:0]   hdr_frm_c;
  logic               hdr_bad_c;
  logic [31:0]        strobe_idx_c;

  // Handshake: stall only during the strobe cycle or while in reset
  always_comb begin
    in_ready = resetn && (state_q != STROBE);
    accept_c = in_valid && in_ready;
  end

  cfg_word_assembler u_asm (
    .UserCLK    (UserCLK),
    .resetn     (resetn),
    .in_data    (in_data),
    .accept     (accept_c),
    .clear      (asm_clear_c),
    .word       (word_c),
    .word_valid (word_valid_c),
    .window     (window_c)
  );

  // Header field extraction, range check and full-width strobe index
  always_comb begin
    hdr_col_c    = word_c[COL_HI:COL_LO];
    hdr_frm_c    = word_c[FRM_HI:FRM_LO];
    hdr_bad_c    = (32'(hdr_col_c) >= NumColumns) ||
                   (32'(hdr_frm_c) >= MaxFramesPerCol);
    strobe_idx_c = 32'(col_q) * MaxFramesPerCol + 32'(frm_q);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    frm_d        = frm_q;
    wcnt_d       = wcnt_q;
    frame_data_d = FrameData;
    strobe_d     = '0;
    done_d       = cfg_done;
    error_d      = cfg_error;
    asm_clear_c  = 1'b0;

    case (state_q)
      HUNT: begin
        if (accept_c && (window_c == SYNC_WORD)) begin
          asm_clear_c = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          state_d     = HEADER;
        end
      end
      HEADER: begin
        // A repeated sync word is simply skipped
        if (word_valid_c && (word_c != SYNC_WORD)) begin
          if (word_c[DESYNC_BIT]) begin
            done_d  = 1'b1;
            state_d = HUNT;
          end else if (hdr_bad_c) begin
            error_d = 1'b1;
            state_d = HUNT;
          end else begin
            col_d   = hdr_col_c;
            frm_d   = hdr_frm_c;
            wcnt_d  = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (word_valid_c) begin
          for (int unsigned r = 0; r < NumRows; r++) begin
            if (wcnt_q == WcntW'(r)) begin
              frame_data_d[r*WORD_W +: WORD_W] = word_c;
            end
          end
          if (wcnt_q == WcntW'(NumRows - 1)) begin
            state_d = STROBE;
            for (int i = 0; i < int'(StrobeW); i++) begin
              strobe_d[i] = (32'(i) == strobe_idx_c);
            end
          end else begin
            wcnt_d = wcnt_q + WcntW'(1);
          end
        end
      end
      STROBE: begin
        state_d = HEADER;
      end
      default: begin
        state_d = HUNT;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      state_q     <= HUNT;
      col_q       <= '0;
      frm_q       <= '0;
      wcnt_q      <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      cfg_done    <= 1'b0;
      cfg_error   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      frm_q       <= frm_d;
      wcnt_q      <= wcnt_d;
      FrameData   <= frame_data_d;
      FrameStrobe <= strobe_d;
      cfg_done    <= done_d;
      cfg_error   <= error_d;
    end
  end

endmodule

// File: tb/tb_config_frame_loader.sv
// Self-checking bench for config_frame_loader: vector table plus strobe scoreboard.
module tb_config_frame_loader;
  import config_frame_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned NC = 4;
  localparam int unsigned MF = 20;
  localparam int unsigned SW = NC * MF;
  localparam int unsigned DW = 32 * NR;

  logic          UserCLK;
  logic          resetn;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] FrameData;
  logic [SW-1:0] FrameStrobe;
  logic          cfg_done;
  logic          cfg_error;

  config_frame_loader #(
    .NumRows         (NR),
    .NumColumns      (NC),
    .MaxFramesPerCol (MF)
  ) dut (
    .UserCLK     (UserCLK),
    .resetn      (resetn),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .cfg_done    (cfg_done),
    .cfg_error   (cfg_error)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  typedef struct {
    logic [31:0] hdr;
    logic [31:0] d0;
    logic [31:0] d1;
    bit          strobe;
    int          idx;
    bit          err;
    bit          done;
    state_e      st;
  } vec_t;

  typedef struct {
    int          idx;
    logic [DW-1:0] data;
  } exp_t;

  vec_t  vecs[9];
  exp_t  sb[$];
  int    total = 0;
  int    bad   = 0;
  bit    mon_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] onehot(input int idx);
    logic [SW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(SW); i++) v[i] = (i == idx);
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int budget;
    int n;
    if (stall) begin
      n = int'($urandom_range(0, 3));
      repeat (n) begin
        @(negedge UserCLK);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    @(negedge UserCLK);
    in_data  = b;
    in_valid = 1'b1;
    budget   = 50;
    while (!in_ready && budget > 0) begin
      @(negedge UserCLK);
      budget--;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL byte_accept_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(posedge UserCLK);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], stall);
  endtask

  task automatic send_sync();
    send_word(SYNC_WORD, 1'b0);
  endtask

  // Header + NR data words, then check latency and width of the strobe
  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] d0,
                            input logic [31:0] d1, input int idx, input bit stall);
    exp_t e;
    send_word(hdr, stall);
    send_word(d0, stall);
    send_word(d1, stall);
    e.idx  = idx;
    e.data = {d1, d0};
    sb.push_back(e);
    @(negedge UserCLK);
    chk("strobe_latency", 128'(FrameStrobe), 128'(onehot(idx)));
    chk("strobe_ready_low", 128'(in_ready), 128'(0));
    @(negedge UserCLK);
    chk("strobe_one_cycle", 128'(FrameStrobe), 128'(0));
    chk("data_hold", 128'(FrameData), 128'({d1, d0}));
  endtask

  // Scoreboard: every strobe must match the oldest expected frame
  always @(negedge UserCLK) begin
    exp_t e;
    if (mon_en && (FrameStrobe != '0)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got %h expected none", FrameStrobe);
      end else begin
        e = sb.pop_front();
        chk("sb_strobe", 128'(FrameStrobe), 128'(onehot(e.idx)));
        chk("sb_data", 128'(FrameData), 128'(e.data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    vecs[0] = '{hdr:32'h0000_0103, d0:32'h1122_3344, d1:32'h5566_7788, strobe:1, idx:23, err:0, done:0, st:HEADER};
    vecs[1] = '{hdr:32'h0000_0000, d0:32'hDEAD_BEEF, d1:32'h0123_4567, strobe:1, idx:0,  err:0, done:0, st:HEADER};
    vecs[2] = '{hdr:32'h0000_0313, d0:32'hA5A5_A5A5, d1:32'h5A5A_5A5A, strobe:1, idx:79, err:0, done:0, st:HEADER};
    vecs[3] = '{hdr:32'h0000_0500, d0:32'h0,         d1:32'h0,         strobe:0, idx:0,  err:1, done:0, st:HUNT};
    vecs[4] = '{hdr:32'h0000_0014, d0:32'h0,         d1:32'h0,         strobe:0, idx:0,  err:1, done:0, st:HUNT};
    vecs[5] = '{hdr:32'h8000_0000, d0:32'h0,         d1:32'h0,         strobe:0, idx:0,  err:0, done:1, st:HUNT};
    vecs[6] = '{hdr:32'h0000_02E7, d0:32'hCAFE_F00D, d1:32'h0BAD_C0DE, strobe:1, idx:47, err:0, done:0, st:HEADER};
    vecs[7] = '{hdr:32'h0000_0400, d0:32'h0,         d1:32'h0,         strobe:0, idx:0,  err:1, done:0, st:HUNT};
    vecs[8] = '{hdr:32'h0000_0013, d0:32'h0F0F_0F0F, d1:32'hF0F0_F0F0, strobe:1, idx:19, err:0, done:0, st:HEADER};

    // Reset state
    repeat (3) @(negedge UserCLK);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_frame_data", 128'(FrameData), 128'(0));
    chk("rst_strobe", 128'(FrameStrobe), 128'(0));
    chk("rst_done", 128'(cfg_done), 128'(0));
    chk("rst_error", 128'(cfg_error), 128'(0));
    chk("rst_state", 128'(dut.state_q), 128'(HUNT));
    mon_en = 1'b1;
    resetn = 1'b1;
    @(negedge UserCLK);
    chk("ready_after_rst", 128'(in_ready), 128'(1));

    // Misaligned sync followed by one frame
    send_byte(8'h00, 1'b0);
    send_sync();
    chk("sync_state", 128'(dut.state_q), 128'(HEADER));
    chk("sync_done", 128'(cfg_done), 128'(0));
    chk("sync_strobe", 128'(FrameStrobe), 128'(0));
    send_frame(32'h0000_0103, 32'h1122_3344, 32'h5566_7788, 23, 1'b0);

    // Desync, then bytes in HUNT must be ignored
    send_word(32'h8000_0000, 1'b0);
    chk("desync_state", 128'(dut.state_q), 128'(HUNT));
    chk("desync_done", 128'(cfg_done), 128'(1));
    chk("desync_error", 128'(cfg_error), 128'(0));
    send_word(32'h0000_0103, 1'b0);
    send_word(32'h1122_3344, 1'b0);
    send_word(32'h5566_7788, 1'b0);
    repeat (3) @(negedge UserCLK);
    chk("ignored_state", 128'(dut.state_q), 128'(HUNT));
    chk("ignored_done", 128'(cfg_done), 128'(1));

    // Vector table: each entry re-syncs (a resync in HEADER is skipped)
    for (int v = 0; v < 9; v++) begin
      send_sync();
      chk("vec_sync_state", 128'(dut.state_q), 128'(HEADER));
      if (vecs[v].strobe) begin
        send_frame(vecs[v].hdr, vecs[v].d0, vecs[v].d1, vecs[v].idx, 1'b0);
      end else begin
        send_word(vecs[v].hdr, 1'b0);
      end
      chk("vec_error", 128'(cfg_error), 128'(vecs[v].err));
      chk("vec_done", 128'(cfg_done), 128'(vecs[v].done));
      chk("vec_state", 128'(dut.state_q), 128'(vecs[v].st));
    end

    // Error cleared by a following sync
    send_word(32'h0000_0500, 1'b0);
    chk("err_set", 128'(cfg_error), 128'(1));
    send_sync();
    chk("err_cleared", 128'(cfg_error), 128'(0));

    // Random stalls must not change data or index
    send_frame(32'h0000_0208, 32'h1357_9BDF, 32'h2468_ACE0, 48, 1'b1);
    send_frame(32'h0000_0208, 32'h1357_9BDF, 32'h2468_ACE0, 48, 1'b0);

    // Reset mid-frame: no strobe, data cleared, new sync required
    send_word(32'h0000_0101, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    @(negedge UserCLK);
    resetn = 1'b0;
    @(negedge UserCLK);
    chk("midrst_ready", 128'(in_ready), 128'(0));
    @(negedge UserCLK);
    chk("midrst_data", 128'(FrameData), 128'(0));
    chk("midrst_state", 128'(dut.state_q), 128'(HUNT));
    resetn = 1'b1;
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_word(32'h1111_1111, 1'b0);
    send_word(32'h0000_0101, 1'b0);
    send_word(32'h2222_2222, 1'b0);
    send_word(32'h3333_3333, 1'b0);
    repeat (3) @(negedge UserCLK);
    chk("nosync_state", 128'(dut.state_q), 128'(HUNT));
    chk("nosync_data", 128'(FrameData), 128'(0));
    send_sync();
    send_frame(32'h0000_0101, 32'h4444_4444, 32'h5555_5555, 21, 1'b0);

    repeat (2) @(negedge UserCLK);
    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
